// File: rtl/tap_sequencer_if.sv
// Host-side command/response bundle for tap_sequencer.
// cmd_tlr exists only when TAP_SEQ_TLR_CMD_EN is defined.
interface tap_sequencer_if #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = $clog2(DATA_W)
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_is_ir;
   logic [LEN_W-1:0]  cmd_len;
   logic [DATA_W-1:0] cmd_data;
`ifdef TAP_SEQ_TLR_CMD_EN
   logic              cmd_tlr;
`endif
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;

   modport master (
`ifdef TAP_SEQ_TLR_CMD_EN
      output cmd_tlr,
`endif
      output cmd_valid, cmd_is_ir, cmd_len, cmd_data,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
`ifdef TAP_SEQ_TLR_CMD_EN
      input  cmd_tlr,
`endif
      input  cmd_valid, cmd_is_ir, cmd_len, cmd_data,
      output cmd_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/tap_sequencer.sv
// JTAG TAP scan sequencer: runs one IR or DR scan per host command, all outputs registered.
// Optional feature macro TAP_SEQ_TLR_CMD_EN adds a host-requested Test-Logic-Reset command.
module tap_sequencer #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = $clog2(DATA_W)
) (
   input  logic             tck,
   input  logic             reset,
   tap_sequencer_if.slave   bus,
   output logic             tms,
   output logic             tdi,
   input  logic             tdo,
   output logic             busy
);
   typedef enum logic [2:0] {
      TLR, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE
   } state_t;

   localparam logic [LEN_W:0] FULL_N = (LEN_W+1)'(DATA_W);

   state_t            state_reg;
   logic [2:0]        tlr_cnt_reg;
   logic [LEN_W:0]    cnt_reg;
   logic [LEN_W:0]    n_reg;
   logic              is_ir_reg;
   logic [DATA_W-1:0] data_reg;
   logic [DATA_W-1:0] cap_reg;
   logic              tms_reg;
   logic              tdi_reg;
   logic              ready_reg;
   logic              busy_reg;
   logic              rsp_valid_reg;
   logic [DATA_W-1:0] rsp_data_reg;
`ifdef TAP_SEQ_TLR_CMD_EN
   logic              tlr_cmd_reg;
`endif

   logic [LEN_W:0]    last_idx;
   assign last_idx = n_reg - 1'b1;

   assign tms           = tms_reg;
   assign tdi           = tdi_reg;
   assign busy          = busy_reg;
   assign bus.cmd_ready = ready_reg;
   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_data  = rsp_data_reg;

   // Each register holds the value for the cycle that follows the edge; the
   // state label names the TAP-level action being driven in that cycle.
   always_ff @(posedge tck) begin
      if (reset) begin
         state_reg     <= TLR;
         tlr_cnt_reg   <= '0;
         cnt_reg       <= '0;
         n_reg         <= '0;
         is_ir_reg     <= 1'b0;
         data_reg      <= '0;
         cap_reg       <= '0;
         tms_reg       <= 1'b1;
         tdi_reg       <= 1'b0;
         ready_reg     <= 1'b0;
         busy_reg      <= 1'b1;
         rsp_valid_reg <= 1'b0;
         rsp_data_reg  <= '0;
`ifdef TAP_SEQ_TLR_CMD_EN
         tlr_cmd_reg   <= 1'b0;
`endif
      end else begin
         rsp_valid_reg <= 1'b0;
         tdi_reg       <= 1'b0;
         case (state_reg)
            TLR: begin
               if (tlr_cnt_reg < 3'd4) begin
                  tlr_cnt_reg <= tlr_cnt_reg + 3'd1;
                  tms_reg     <= 1'b1;
               end else if (tlr_cnt_reg == 3'd4) begin
                  tlr_cnt_reg <= 3'd5;
                  tms_reg     <= 1'b0;
               end else begin
                  state_reg   <= IDLE;
                  tlr_cnt_reg <= '0;
                  tms_reg     <= 1'b0;
                  ready_reg   <= 1'b1;
                  busy_reg    <= 1'b0;
`ifdef TAP_SEQ_TLR_CMD_EN
                  if (tlr_cmd_reg) begin
                     rsp_valid_reg <= 1'b1;
                     rsp_data_reg  <= '0;
                     tlr_cmd_reg   <= 1'b0;
                  end
`endif
               end
            end
            IDLE: begin
               tms_reg <= 1'b0;
               if (bus.cmd_valid) begin
                  ready_reg <= 1'b0;
                  busy_reg  <= 1'b1;
                  is_ir_reg <= bus.cmd_is_ir;
                  n_reg     <= (bus.cmd_len == '0) ? FULL_N : {1'b0, bus.cmd_len};
                  data_reg  <= bus.cmd_data;
                  cap_reg   <= '0;
                  cnt_reg   <= '0;
                  tms_reg   <= 1'b1;
                  state_reg <= SEL_DR;
`ifdef TAP_SEQ_TLR_CMD_EN
                  // A TLR request overrides the scan type entirely.
                  if (bus.cmd_tlr) begin
                     state_reg   <= TLR;
                     tlr_cnt_reg <= '0;
                     tlr_cmd_reg <= 1'b1;
                  end
`endif
               end
            end
            SEL_DR: begin
               if (is_ir_reg) begin
                  state_reg <= SEL_IR;
                  tms_reg   <= 1'b1;
               end else begin
                  state_reg <= CAPTURE;
                  cnt_reg   <= '0;
                  tms_reg   <= 1'b0;
               end
            end
            SEL_IR: begin
               state_reg <= CAPTURE;
               cnt_reg   <= '0;
               tms_reg   <= 1'b0;
            end
            CAPTURE: begin
               tms_reg <= 1'b0;
               if (cnt_reg == '0) begin
                  cnt_reg <= cnt_reg + 1'b1;
               end else begin
                  state_reg <= SHIFT;
                  cnt_reg   <= '0;
                  tdi_reg   <= data_reg[0];
                  data_reg  <= {1'b0, data_reg[DATA_W-1:1]};
                  tms_reg   <= (last_idx == '0);
               end
            end
            SHIFT: begin
               cap_reg[cnt_reg[LEN_W-1:0]] <= tdo;
               if (cnt_reg == last_idx) begin
                  state_reg <= EXIT1;
                  tms_reg   <= 1'b1;
               end else begin
                  cnt_reg   <= cnt_reg + 1'b1;
                  tdi_reg   <= data_reg[0];
                  data_reg  <= {1'b0, data_reg[DATA_W-1:1]};
                  tms_reg   <= ((cnt_reg + 1'b1) == last_idx);
               end
            end
            EXIT1: begin
               state_reg <= UPDATE;
               tms_reg   <= 1'b0;
            end
            UPDATE: begin
               state_reg     <= IDLE;
               tms_reg       <= 1'b0;
               ready_reg     <= 1'b1;
               busy_reg      <= 1'b0;
               rsp_valid_reg <= 1'b1;
               rsp_data_reg  <= cap_reg;
            end
            default: begin
               state_reg   <= TLR;
               tlr_cnt_reg <= '0;
               tms_reg     <= 1'b1;
               ready_reg   <= 1'b0;
               busy_reg    <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_tap_sequencer.sv
// Directed self-checking bench for tap_sequencer; outputs sampled on the falling edge of tck.
// Exercises the TLR command path too when TAP_SEQ_TLR_CMD_EN is defined.
module tb_tap_sequencer;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 5;

   logic        tck = 1'b0;
   logic        reset = 1'b1;
   logic        tms;
   logic        tdi;
   logic        tdo = 1'b0;
   logic        busy;
   int          tdo_mode = 0;   // 0: loopback of tdi, 1: constant 1, 2: constant 0
   int          n_assert = 0;
   int          n_fail = 0;
   logic [31:0] prev_rsp = '0;

   tap_sequencer_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

   tap_sequencer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .tck   (tck),
      .reset (reset),
      .bus   (bus),
      .tms   (tms),
      .tdi   (tdi),
      .tdo   (tdo),
      .busy  (busy)
   );

   always #5 tck = ~tck;

   always @(negedge tck) tdo = (tdo_mode == 0) ? tdi : tdo_mode[0];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Entered at the falling edge of the first TLR cycle; ends in the first IDLE cycle.
   task automatic tlr_seq(input string tag, input logic rsp7);
      for (int c = 1; c <= 7; c++) begin
         chk({tag, "_tms"},   {31'b0, tms},           (c <= 5) ? 32'd1 : 32'd0);
         chk({tag, "_tdi"},   {31'b0, tdi},           32'd0);
         chk({tag, "_ready"}, {31'b0, bus.cmd_ready}, (c == 7) ? 32'd1 : 32'd0);
         chk({tag, "_rspv"},  {31'b0, bus.rsp_valid}, (c == 7) ? {31'b0, rsp7} : 32'd0);
         if (c < 7) @(negedge tck);
      end
      $display("tlr %s done", tag);
   endtask

   // Entered in an IDLE cycle; ends in the rsp_valid cycle.
   task automatic scan(input bit is_ir, input logic [4:0] len, input logic [31:0] data,
                       input int mode, input logic [31:0] exp_rsp);
      int n, pre, nbusy, i;
      logic et, ed;
      n     = (len == 0) ? 32 : int'(len);
      pre   = is_ir ? 4 : 3;
      nbusy = pre + n + 2;
      tdo_mode      = mode;
      bus.cmd_valid = 1'b1;
      bus.cmd_is_ir = is_ir;
      bus.cmd_len   = len;
      bus.cmd_data  = data;
      @(negedge tck);
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = ~data;
      bus.cmd_len   = len + 5'd3;
      bus.cmd_is_ir = ~is_ir;
      for (int c = 1; c <= nbusy; c++) begin
         ed = 1'b0;
         if (c == 1) et = 1'b1;
         else if (c == 2) et = is_ir;
         else if (c <= pre) et = 1'b0;
         else if (c <= pre + n) begin
            i  = c - pre - 1;
            et = (i == n - 1);
            ed = data[i];
         end
         else if (c == pre + n + 1) et = 1'b1;
         else et = 1'b0;
         chk("scan_tms",   {31'b0, tms},           {31'b0, et});
         chk("scan_tdi",   {31'b0, tdi},           {31'b0, ed});
         chk("scan_busy",  {31'b0, busy},          32'd1);
         chk("scan_ready", {31'b0, bus.cmd_ready}, 32'd0);
         chk("scan_rspv",  {31'b0, bus.rsp_valid}, 32'd0);
         if (c == 1) chk("scan_rsp_hold", bus.rsp_data, prev_rsp);
         @(negedge tck);
      end
      chk("scan_done_rspv",  {31'b0, bus.rsp_valid}, 32'd1);
      chk("scan_done_ready", {31'b0, bus.cmd_ready}, 32'd1);
      chk("scan_done_busy",  {31'b0, busy},          32'd0);
      chk("scan_done_data",  bus.rsp_data,           exp_rsp);
      prev_rsp = exp_rsp;
      $display("scan ir=%0d len=%0d data=%h rsp=%h", is_ir, len, data, bus.rsp_data);
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_is_ir = 1'b0;
      bus.cmd_len   = '0;
      bus.cmd_data  = '0;
`ifdef TAP_SEQ_TLR_CMD_EN
      bus.cmd_tlr   = 1'b0;
`endif
      repeat (2) @(negedge tck);
      chk("rst_tms",   {31'b0, tms},           32'd1);
      chk("rst_tdi",   {31'b0, tdi},           32'd0);
      chk("rst_ready", {31'b0, bus.cmd_ready}, 32'd0);
      chk("rst_busy",  {31'b0, busy},          32'd1);
      chk("rst_rspv",  {31'b0, bus.rsp_valid}, 32'd0);
      chk("rst_rspd",  bus.rsp_data,           32'd0);
      reset = 1'b0;
      tlr_seq("por", 1'b0);

      scan(1'b0, 5'd8,  32'h0000_00A5, 0, 32'h0000_00A5);
      scan(1'b1, 5'd4,  32'h0000_0003, 1, 32'h0000_000F);
      scan(1'b0, 5'd0,  32'hFFFF_FFFF, 0, 32'hFFFF_FFFF);
      scan(1'b0, 5'd1,  32'h0000_0001, 1, 32'h0000_0001);
      scan(1'b1, 5'd5,  32'h0000_0015, 2, 32'h0000_0000);
      scan(1'b0, 5'd31, 32'hDEAD_BEEF, 0, 32'h5EAD_BEEF);

      // Back-to-back: cmd_valid stays high through the first response.
      tdo_mode      = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_is_ir = 1'b0;
      bus.cmd_len   = 5'd2;
      bus.cmd_data  = 32'h0000_0002;
      @(negedge tck);
      bus.cmd_len   = 5'd3;
      bus.cmd_data  = 32'h0000_0001;
      repeat (7) @(negedge tck);
      chk("b2b_first_rspv",  {31'b0, bus.rsp_valid}, 32'd1);
      chk("b2b_first_ready", {31'b0, bus.cmd_ready}, 32'd1);
      chk("b2b_first_data",  bus.rsp_data,           32'h0000_0002);
      @(negedge tck);
      bus.cmd_valid = 1'b0;
      chk("b2b_second_busy", {31'b0, busy},          32'd1);
      chk("b2b_second_tms",  {31'b0, tms},           32'd1);
      chk("b2b_second_rspv", {31'b0, bus.rsp_valid}, 32'd0);
      chk("b2b_first_hold",  bus.rsp_data,           32'h0000_0002);
      repeat (8) @(negedge tck);
      chk("b2b_second_rspv2", {31'b0, bus.rsp_valid}, 32'd1);
      chk("b2b_second_data",  bus.rsp_data,           32'h0000_0001);
      prev_rsp = 32'h0000_0001;
      $display("b2b rsp1=00000002 rsp2=%h", bus.rsp_data);

`ifdef TAP_SEQ_TLR_CMD_EN
      bus.cmd_valid = 1'b1;
      bus.cmd_tlr   = 1'b1;
      bus.cmd_is_ir = 1'b1;
      @(negedge tck);
      bus.cmd_valid = 1'b0;
      bus.cmd_tlr   = 1'b0;
      chk("tlrcmd_busy", {31'b0, busy}, 32'd1);
      tlr_seq("tlrcmd", 1'b1);
      chk("tlrcmd_data", bus.rsp_data, 32'd0);
      prev_rsp = 32'd0;
`endif

      // Reset during shift cycle 3 of a 16-bit DR scan.
      bus.cmd_valid = 1'b1;
      bus.cmd_is_ir = 1'b0;
      bus.cmd_len   = 5'd16;
      bus.cmd_data  = 32'h0000_BEEF;
      @(negedge tck);
      bus.cmd_valid = 1'b0;
      repeat (6) @(negedge tck);
      chk("abort_tms", {31'b0, tms}, 32'd0);
      chk("abort_tdi", {31'b0, tdi}, 32'd1);
      reset = 1'b1;
      @(negedge tck);
      reset = 1'b0;
      chk("abort_rspd", bus.rsp_data, 32'd0);
      chk("abort_busy", {31'b0, busy}, 32'd1);
      tlr_seq("abort", 1'b0);
      prev_rsp = 32'd0;

      scan(1'b0, 5'd3, 32'h0000_0005, 0, 32'h0000_0005);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/tap_sequencer.md
TAP_SEQUENCER -- requirements
Module: tap_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, maximum shift length in bits; a power of two, at least 2.
REQ-002 SHALL have parameter LEN_W, default $clog2(DATA_W), width of cmd_len.
REQ-003 SHALL have port tck  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cmd_valid  input  1  host command request.
REQ-006 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-007 SHALL have port cmd_is_ir  input  1  1 = IR scan, 0 = DR scan.
REQ-008 SHALL have port cmd_len  input  LEN_W  shift length; 0 encodes DATA_W.
REQ-009 SHALL have port cmd_data  input  DATA_W  bits to shift in, LSB first.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle pulse, scan complete.
REQ-011 SHALL have port rsp_data  output  DATA_W  captured TDO bits, LSB first.
REQ-012 SHALL have port tms  output  1  registered TMS to TAP.
REQ-013 SHALL have port tdi  output  1  registered TDI to TAP.
REQ-014 SHALL have port tdo  input  1  TDO from TAP, sampled on rising tck.
REQ-015 SHALL have port busy  output  1  high whenever cmd_ready is low.

Function
REQ-016 SHALL implement states TLR, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE.
REQ-017 SHALL enter TLR after reset: drive tms=1 for 5 cycles, then tms=0 for 1 cycle, then go to IDLE.
REQ-018 SHALL assert cmd_ready only in IDLE; a command is accepted on a rising edge with cmd_valid && cmd_ready.
REQ-019 SHALL latch cmd_is_ir, cmd_len and cmd_data at acceptance; later changes to the inputs are ignored.
REQ-020 SHALL drive the following per-cycle sequence after acceptance (cycle 1 = first cycle after the accepting edge).
- DR scan: tms 1 (SEL_DR), 0 (CAPTURE), 0 (enter SHIFT).
- IR scan: tms 1, 1 (SEL_DR, SEL_IR), 0, 0.
REQ-021 SHALL then spend N cycles in SHIFT (N = cmd_len, or DATA_W if cmd_len is 0).
- Shift cycle i drives tdi = data[i].
- tms = 0 for i < N-1 and tms = 1 for i = N-1.
REQ-022 SHALL drive tms=1 for one cycle (EXIT1->Update), then tms=0 for one cycle (UPDATE->Idle), then return to IDLE.
REQ-023 SHALL produce total busy cycles per command of N+5 (DR) or N+6 (IR), followed by IDLE.
REQ-024 SHALL sample tdo on the rising edge ending shift cycle i into capture bit i; capture bits >= N SHALL be 0.
REQ-025 SHALL pulse rsp_valid for exactly one cycle, in the cycle after the final tms=0 cycle, coincident with cmd_ready returning high.
REQ-026 SHALL hold rsp_data stable from the rsp_valid pulse until the next rsp_valid pulse; rsp_valid has no backpressure.
REQ-027 SHALL drive tdi=0 in every non-SHIFT cycle.
REQ-028 SHALL allow back-to-back commands: cmd_valid held high is accepted on the same edge that asserts rsp_valid, with no extra idle cycle.
REQ-029 SHALL handle N=1 correctly: a single shift cycle with tms=1.
REQ-030 SHALL use a shift counter of LEN_W+1 bits so that N=DATA_W never wraps.

Reset
REQ-031 SHALL on reset set tms=1, tdi=0, cmd_ready=0, busy=1, rsp_valid=0, rsp_data=0 and the state to TLR with count 0.
REQ-032 SHALL let reset asserted mid-scan abort the scan, discard partial capture, emit no rsp_valid, and restart TLR.

Configuration
REQ-033 SHALL, with TAP_SEQ_TLR_CMD_EN defined, add input cmd_tlr (1 bit).
- A command accepted with cmd_tlr=1 runs the REQ-017 sequence (5×tms=1, 1×tms=0).
- It then pulses rsp_valid with rsp_data=0.
- cmd_tlr takes priority over cmd_is_ir.
REQ-034 SHALL, without TAP_SEQ_TLR_CMD_EN, omit cmd_tlr; TLR is then entered only via reset.

Verification
REQ-035 SHALL cover post-reset: release reset -> tms 1,1,1,1,1,0, cmd_ready rises in cycle 7.
REQ-036 SHALL cover DR scan: len=8, data=0xA5, tdo loopback of tdi -> tms 1,0,0,0×7,1,1,0; tdi 1,0,1,0,0,1,0,1; rsp_data=0xA5 at cycle 14.
REQ-037 SHALL cover IR scan: len=4, data=0x3, tdo=1 constant -> tms 1,1,0,0,0,0,0,1,1,0; rsp_data=0xF.
REQ-038 SHALL cover the boundary case: len=0 (N=32), data=0xFFFFFFFF -> 32 shift cycles, busy 37 cycles; len=1 -> single shift cycle with tms=1.
REQ-039 SHALL cover reset asserted in shift cycle 3 of a len=16 scan -> no rsp_valid, full TLR sequence repeats.
REQ-040 SHALL cover back-to-back: two DR commands with cmd_valid held high -> the second is accepted on the rsp_valid edge of the first; with TAP_SEQ_TLR_CMD_EN, cmd_tlr=1 -> 5×tms=1, 1×tms=0, rsp_data=0.
